// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types, sizes and config-word helper for the adc sweep path
package adc_pkg;

   localparam int CFG_W = 5;
   localparam int NSLOT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESET = 2'd1,
      SKIP  = 2'd2,
      RUN   = 2'd3
   } state_t;

   typedef logic [NSLOT-1:0][CFG_W-1:0] listing_t;
   typedef logic [NSLOT-1:0][2:0]       slot_ch_t;

   // Single-ended config word for physical channel ch: {S/D, O/S, S1, S0, UNI}
   function automatic logic [CFG_W-1:0] ch_cfg_word(input logic [2:0] ch, input logic uni);
      return {1'b1, ch[0], ch[2], ch[1], uni};
   endfunction

endpackage

// File: rtl/adc_slot_packer.sv
// rtl/adc_slot_packer.sv - packs a channel mask into slot listing, count and slot-to-channel map
module adc_slot_packer
   import adc_pkg::*;
(
   input  logic [NSLOT-1:0] i_mask,
   input  logic             i_uni,
   output listing_t         o_listing,
   output logic [2:0]       o_count,
   output slot_ch_t         o_slot_ch,
   output logic             o_nonzero
);

   // Enabled channels fill slots in ascending order; unused slots repeat slot 0
   always_comb begin
      listing_t   lst;
      slot_ch_t   sch;
      logic [3:0] k;
      lst = '0;
      sch = '0;
      k   = 4'd0;
      for (int n = 0; n < NSLOT; n++) begin
         if (i_mask[n]) begin
            lst[k[2:0]] = ch_cfg_word(3'(n), i_uni);
            sch[k[2:0]] = 3'(n);
            k           = k + 4'd1;
         end
      end
      for (int s = 1; s < NSLOT; s++) begin
         if (4'(s) >= k) begin
            lst[s] = lst[0];
            sch[s] = sch[0];
         end
      end
      o_listing = lst;
      o_slot_ch = sch;
      o_count   = 3'(k - 4'd1);
      o_nonzero = |i_mask;
   end

endmodule

// File: rtl/adc_sweep_scheduler.sv
// rtl/adc_sweep_scheduler.sv - sweep scheduler, reconfiguration sequencer and result demux/averager
module adc_sweep_scheduler
   import adc_pkg::*;
#(
   parameter int AVG_LOG2   = 0,
   parameter int RST_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ch_enable,
   input  logic        cfg_uni,
   input  logic        apply,
   output logic        adc_rst,
   output logic [2:0]  cfg_count,
   output listing_t    cfg_listing,
   input  logic [15:0] sample,
   input  logic        sample_valid,
   output logic        res_valid,
   output logic [2:0]  res_ch,
   output logic [15:0] res_data,
   output logic        sweep_done,
   output logic        busy
);

   localparam logic [4:0]  AVG_LAST = 5'((1 << AVG_LOG2) - 1);
   localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

   state_t      r_state, w_next;
   logic        r_pend, r_pend_uni;
   logic [7:0]  r_pend_mask;
   logic [15:0] r_rst_cnt;
   logic [4:0]  r_avg_cnt;
   logic [15:0] r_acc [NSLOT];
   logic [2:0]  r_cfg_count;
   listing_t    r_cfg_listing;
   slot_ch_t    r_slot_ch;
   logic        r_res_valid, r_sweep_done;
   logic [2:0]  r_res_ch;
   logic [15:0] r_res_data;

   // An apply in the same cycle as a boundary decision wins over the stored pending config
   logic [7:0]  w_eff_mask;
   logic        w_eff_uni, w_any_pend;
   listing_t    w_listing;
   slot_ch_t    w_slot_ch;
   logic [2:0]  w_count, w_slot;
   logic        w_nonzero, w_accept, w_sweep_end, w_emit, w_enter_reset, w_enter_idle;
   logic [3:0]  w_tag;
   logic [11:0] w_code;
   logic [15:0] w_sum;

   assign w_eff_mask = apply ? ch_enable : r_pend_mask;
   assign w_eff_uni  = apply ? cfg_uni : r_pend_uni;
   assign w_any_pend = apply | r_pend;

   adc_slot_packer u_packer (
      .i_mask    (w_eff_mask),
      .i_uni     (w_eff_uni),
      .o_listing (w_listing),
      .o_count   (w_count),
      .o_slot_ch (w_slot_ch),
      .o_nonzero (w_nonzero)
   );

   assign w_tag       = sample[15:12];
   assign w_slot      = sample[14:12];
   assign w_code      = sample[11:0];
   assign w_accept    = (r_state == RUN) && sample_valid && (w_tag <= {1'b0, r_cfg_count});
   assign w_sweep_end = w_accept && (w_slot == r_cfg_count);
   assign w_emit      = w_accept && (r_avg_cnt == AVG_LAST);
   assign w_sum       = ((r_avg_cnt == 5'd0) ? 16'd0 : r_acc[w_slot]) + {4'd0, w_code};

   assign w_enter_reset = (w_next == RESET) && (r_state != RESET);
   assign w_enter_idle  = (w_next == IDLE) && (r_state != IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state: reconfiguration only at sweep boundaries or from idle
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (apply && w_nonzero) w_next = RESET;
         RESET:   if (r_rst_cnt == RST_LAST) w_next = SKIP;
         SKIP:    if (sample_valid) w_next = RUN;
         default: if (w_sweep_end && w_any_pend) w_next = w_nonzero ? RESET : IDLE;
      endcase
   end

   // State-decoded outputs: adc held in reset while idle or reconfiguring
   always_comb begin
      adc_rst = 1'b0;
      busy    = 1'b0;
      case (r_state)
         IDLE:    adc_rst = 1'b1;
         RESET:   begin adc_rst = 1'b1; busy = 1'b1; end
         SKIP:    busy = 1'b1;
         default: ;
      endcase
   end

   // Pending config capture and active config load on reset entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend        <= 1'b0;
         r_pend_mask   <= '0;
         r_pend_uni    <= 1'b0;
         r_rst_cnt     <= '0;
         r_cfg_count   <= '0;
         r_cfg_listing <= '0;
         r_slot_ch     <= '0;
      end else begin
         if (apply) begin
            r_pend_mask <= ch_enable;
            r_pend_uni  <= cfg_uni;
         end
         if (w_enter_reset || w_enter_idle) r_pend <= 1'b0;
         else if (apply)                    r_pend <= 1'b1;
         if (r_state == RESET) r_rst_cnt <= r_rst_cnt + 16'd1;
         if (w_enter_reset) begin
            r_rst_cnt     <= '0;
            r_cfg_count   <= w_count;
            r_cfg_listing <= w_listing;
            r_slot_ch     <= w_slot_ch;
         end
      end
   end

   // Per-slot accumulation, sweep counting and registered result emission
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_avg_cnt    <= '0;
         r_res_valid  <= 1'b0;
         r_sweep_done <= 1'b0;
         r_res_ch     <= '0;
         r_res_data   <= '0;
         for (int i = 0; i < NSLOT; i++) r_acc[i] <= '0;
      end else begin
         r_res_valid  <= w_emit;
         r_sweep_done <= w_emit && w_sweep_end;
         if (w_emit) begin
            r_res_ch   <= r_slot_ch[w_slot];
            r_res_data <= w_sum >> AVG_LOG2;
         end
         if (w_accept) begin
            r_acc[w_slot] <= w_sum;
            if (w_sweep_end) r_avg_cnt <= (r_avg_cnt == AVG_LAST) ? 5'd0 : r_avg_cnt + 5'd1;
         end
         if (w_enter_reset) begin
            r_avg_cnt <= '0;
            for (int i = 0; i < NSLOT; i++) r_acc[i] <= '0;
         end
      end
   end

   assign cfg_count   = r_cfg_count;
   assign cfg_listing = r_cfg_listing;
   assign res_valid   = r_res_valid;
   assign res_ch      = r_res_ch;
   assign res_data    = r_res_data;
   assign sweep_done  = r_sweep_done;

endmodule

// File: tb/tb_adc_sweep_scheduler.sv
// tb/tb_adc_sweep_scheduler.sv - scoreboard bench for adc_sweep_scheduler with behavioural model
module tb_adc_sweep_scheduler;
   import adc_pkg::*;

   localparam int AVG_LOG2   = 2;
   localparam int RST_CYCLES = 2;
   localparam int NAVG       = 1 << AVG_LOG2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ch_enable;
   logic        cfg_uni, apply, adc_rst, sample_valid, res_valid, sweep_done, busy;
   logic [2:0]  cfg_count, res_ch;
   listing_t    cfg_listing;
   logic [15:0] sample, res_data;

   always #5 clk = ~clk;

   adc_sweep_scheduler #(.AVG_LOG2(AVG_LOG2), .RST_CYCLES(RST_CYCLES)) dut (
      .clk(clk), .rst(rst), .ch_enable(ch_enable), .cfg_uni(cfg_uni), .apply(apply),
      .adc_rst(adc_rst), .cfg_count(cfg_count), .cfg_listing(cfg_listing),
      .sample(sample), .sample_valid(sample_valid), .res_valid(res_valid),
      .res_ch(res_ch), .res_data(res_data), .sweep_done(sweep_done), .busy(busy)
   );

   typedef struct packed {
      logic [2:0]  ch;
      logic [15:0] data;
      logic        done;
   } res_t;

   res_t exp_q[$];
   res_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   // model state: 0 idle, 1 waiting for stale sample, 2 running
   int       m_mode = 0;
   int       m_chans[$];
   logic     m_uni = 1'b0;
   bit       m_pend = 1'b0;
   logic [7:0] m_pmask = 8'h00;
   logic     m_puni = 1'b0;
   int       m_avg = 0;
   int       m_acc[8];
   bit       m_reconf = 1'b0;
   int       m_gen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic void m_start();
      m_chans.delete();
      for (int n = 0; n < 8; n++) if (m_pmask[n]) m_chans.push_back(n);
      m_uni = m_puni;
      m_pend = 1'b0;
      m_avg = 0;
      for (int i = 0; i < 8; i++) m_acc[i] = 0;
      m_mode = 1;
      m_reconf = 1'b1;
      m_gen++;
   endfunction

   function automatic void m_step(bit ap, logic [7:0] m, bit u, bit v, int tag, int code);
      res_t r;
      m_reconf = 1'b0;
      if (ap) begin m_pend = 1'b1; m_pmask = m; m_puni = u; end
      case (m_mode)
         0: if (ap && m != 8'h00) m_start();
         1: if (v) m_mode = 2;
         default: if (v && tag < m_chans.size()) begin
            if (m_avg == 0) m_acc[tag] = code;
            else            m_acc[tag] += code;
            if (m_avg == NAVG - 1) begin
               r.ch   = 3'(m_chans[tag]);
               r.data = 16'(m_acc[tag] / NAVG);
               r.done = (tag == m_chans.size() - 1);
               exp_q.push_back(r);
            end
            if (tag == m_chans.size() - 1) begin
               m_avg = (m_avg + 1) % NAVG;
               if (m_pend) begin
                  if (m_pmask != 8'h00) m_start();
                  else begin m_mode = 0; m_pend = 1'b0; end
               end
            end
         end
      endcase
   endfunction

   function automatic logic [39:0] exp_listing();
      logic [39:0] l;
      int ch;
      l = '0;
      for (int s = 0; s < 8; s++) begin
         ch = m_chans[(s < m_chans.size()) ? s : 0];
         l[5*s +: 5] = {1'b1, ch[0], ch[2], ch[1], m_uni};
      end
      return l;
   endfunction

   task automatic step(input bit ap, input logic [7:0] m, input bit u, input bit v, input int tag, input int code);
      apply = ap; ch_enable = m; cfg_uni = u; sample_valid = v;
      sample = {1'b0, 3'(tag), 12'(code)};
      m_step(ap, m, u, v, tag, code);
      @(posedge clk); #1;
      apply = 1'b0; sample_valid = 1'b0;
   endtask

   task automatic wait_reconfig();
      int hi;
      bit seen_low;
      hi = 0; seen_low = 1'b0;
      for (int c = 0; c < 40 && !seen_low; c++) begin
         @(negedge clk);
         if (adc_rst) hi++;
         else seen_low = 1'b1;
      end
      chk("adc_rst_release", seen_low, 1);
      chk("adc_rst_cycles", hi, RST_CYCLES);
      chk("cfg_count", cfg_count, m_chans.size() - 1);
      chk("cfg_listing", cfg_listing, exp_listing());
      chk("busy_skip", busy, 1);
      step(0, 8'h00, 0, 1, $urandom % 8, $urandom % 4096);
   endtask

   task automatic go(input bit ap, input logic [7:0] m, input bit u, input bit v, input int tag, input int code);
      int mb;
      mb = m_mode;
      step(ap, m, u, v, tag, code);
      if (m_reconf) wait_reconfig();
      else if (mb == 2 && m_mode == 0) begin
         @(negedge clk);
         chk("idle_adc_rst", adc_rst, 1);
         chk("idle_busy", busy, 0);
      end
   endtask

   task automatic chk_reset_vals();
      @(negedge clk);
      chk("rst_adc_rst", adc_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_count", cfg_count, 0);
      chk("rst_cfg_listing", cfg_listing, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_ch", res_ch, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_sweep_done", sweep_done, 0);
   endtask

   // Scoreboard monitor: every presented result must match the oldest expectation
   always @(negedge clk) begin
      if (res_valid) begin
         if (exp_q.size() == 0) chk("result_expected", exp_q.size(), 1);
         else begin
            mon_e = exp_q.pop_front();
            chk("res_ch", res_ch, mon_e.ch);
            chk("res_data", res_data, mon_e.data);
            chk("sweep_done", sweep_done, mon_e.done);
         end
      end else if (sweep_done) chk("stray_sweep_done", sweep_done, 0);
   end

   int nxt, sz, g0, r;
   bit ap;
   logic [7:0] mk;

   initial begin
      rst = 1'b1; apply = 1'b0; ch_enable = 8'h00; cfg_uni = 1'b0;
      sample_valid = 1'b0; sample = 16'h0000;
      repeat (3) @(posedge clk);
      chk_reset_vals();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // mask 0x05 unipolar
      go(1, 8'h05, 1, 0, 0, 0);
      chk("count_05", cfg_count, 1);
      chk("listing0_ch0", cfg_listing[0], 5'b10001);
      chk("listing1_ch2", cfg_listing[1], 5'b10011);
      for (int sw = 0; sw < 4; sw++)
         for (int t = 0; t < 2; t++) go(0, 8'h00, 0, 1, t, $urandom % 4096);

      // switch to CH7 at the boundary, then average 100..400
      go(1, 8'h80, 0, 1, 0, $urandom % 4096);
      go(0, 8'h00, 0, 1, 1, $urandom % 4096);
      go(0, 8'h00, 0, 1, 0, 100);
      go(0, 8'h00, 0, 1, 0, 200);
      go(0, 8'h00, 0, 1, 0, 300);
      go(0, 8'h00, 0, 1, 0, 400);
      chk("avg_250_data", res_data, 250);
      chk("avg_250_ch", res_ch, 7);
      chk("avg_250_done", sweep_done, 1);

      // mask 0x0F, then apply 0x03 while tag 1 arrives in the emitting sweep
      go(1, 8'h0F, 0, 1, 0, $urandom % 4096);
      for (int sw = 0; sw < 3; sw++)
         for (int t = 0; t < 4; t++) go(0, 8'h00, 0, 1, t, $urandom % 4096);
      go(0, 8'h00, 0, 1, 0, $urandom % 4096);
      go(1, 8'h03, 0, 1, 1, $urandom % 4096);
      go(0, 8'h00, 0, 1, 2, $urandom % 4096);
      go(0, 8'h00, 0, 1, 3, $urandom % 4096);
      chk("count_03", cfg_count, 1);

      // two applies in one sweep: last one wins
      go(1, 8'h01, 1, 1, 0, $urandom % 4096);
      go(1, 8'h10, 1, 0, 0, 0);
      go(0, 8'h00, 0, 1, 1, $urandom % 4096);
      chk("count_ch4", cfg_count, 0);
      chk("listing_ch4", cfg_listing, {8{5'b10101}});

      // mask 0 at the boundary parks in idle; samples ignored
      go(1, 8'h00, 0, 1, 0, $urandom % 4096);
      for (int i = 0; i < 4; i++) go(0, 8'h00, 0, 1, $urandom % 2, $urandom % 4096);

      // reset mid-average
      go(1, 8'h06, 1, 0, 0, 0);
      for (int sw = 0; sw < 2; sw++)
         for (int t = 0; t < 2; t++) go(0, 8'h00, 0, 1, t, $urandom % 4096);
      rst = 1'b1;
      chk_reset_vals();
      chk("no_partial_pending", exp_q.size(), 0);
      exp_q.delete();
      m_mode = 0; m_pend = 1'b0; m_avg = 0; m_pmask = 8'h00;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) go(0, 8'h00, 0, 1, $urandom % 2, $urandom % 4096);

      // randomized operation
      nxt = 0;
      for (int i = 0; i < 700; i++) begin
         if (m_mode == 0) begin
            go(1, 8'($urandom_range(1, 255)), 1'($urandom % 2), 0, 0, 0);
            nxt = 0;
         end else begin
            sz = m_chans.size();
            g0 = m_gen;
            r  = $urandom % 16;
            if (r == 0) go(0, 8'h00, 0, 0, 0, 0);
            else if (r == 1 && sz < 8) go(0, 8'h00, 0, 1, sz + ($urandom % (8 - sz)), $urandom % 4096);
            else begin
               ap = ($urandom % 12 == 0);
               mk = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
               go(ap, mk, 1'($urandom % 2), 1, nxt, $urandom % 4096);
               nxt = (nxt + 1) % sz;
            end
            if (m_gen != g0) nxt = 0;
         end
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
